// File: rtl/jogo_pkg.sv
// Shared types and constants for the score/lives/wave sequencer.
package jogo_pkg;

  typedef enum logic [1:0] {
    JOGANDO = 2'd0,
    LIMPA   = 2'd1,
    NOVA    = 2'd2,
    FIM     = 2'd3
  } estado_t;

  typedef logic [3:0] digito_bcd_t;

  localparam logic [15:0] PONTOS_MAX  = 16'h9999;
  localparam logic [15:0] PONTOS_TETO = 16'h9990;

endpackage

// File: rtl/placar_fileira_soma_bcd.sv
// 4-digit BCD score +10 with clamp to 9999 once the sum would pass 9990.
module soma_bcd
  import jogo_pkg::*;
(
  input  logic [15:0] a_i,
  output logic [15:0] soma_o
);

  digito_bcd_t dez;
  digito_bcd_t cen;
  digito_bcd_t mil;

  // Tens digit +1 with ripple carry into hundreds and thousands.
  always_comb begin
    dez    = a_i[7:4];
    cen    = a_i[11:8];
    mil    = a_i[15:12];
    soma_o = a_i;
    if (a_i >= PONTOS_TETO) begin
      soma_o = PONTOS_MAX;
    end else begin
      if (dez == 4'd9) begin
        dez = '0;
        if (cen == 4'd9) begin
          cen = '0;
          mil = mil + 4'd1;
        end else begin
          cen = cen + 4'd1;
        end
      end else begin
        dez = dez + 4'd1;
      end
      soma_o = {mil, cen, dez, a_i[3:0]};
    end
  end

endmodule

// File: rtl/placar_fileira.sv
// Score, lives and wave sequencer fed by the enemy-row block.
// Optional macro PLACAR_RECORDE_EN adds the high-score output `recorde`.
module placar_fileira
  import jogo_pkg::*;
#(
  parameter int unsigned N_INIMIGOS     = 5,
  parameter int unsigned VIDAS_INICIAIS = 3,
  parameter int unsigned ESPERA_ONDA    = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  reiniciarJogo,
  input  logic                  pausa,
  input  logic [N_INIMIGOS-1:0] vivo,
  input  logic [1:0]            n_batidas,
  output logic [15:0]           pontos,
  output logic [1:0]            vidas,
  output logic [3:0]            onda,
  output logic                  nova_onda,
`ifdef PLACAR_RECORDE_EN
  output logic [15:0]           recorde,
`endif
  output logic                  fim_jogo
);

  localparam int unsigned TW       = $clog2(ESPERA_ONDA);
  localparam logic [1:0]  VIDAS_INI = 2'(VIDAS_INICIAIS);

  logic [N_INIMIGOS-1:0] vivo_s1_q, vivo_s2_q, vivo_ant_q;
  logic [1:0]            bat_s1_q, bat_s2_q, bat_ant_q;
  logic [2:0]            pend_q, pend_d;
  logic [8:0]            pend_soma;
  logic [7:0]            abatidos;
  logic [15:0]           pontos_q, pontos_d, pontos_mais10;
  logic [1:0]            vidas_q, vidas_d;
  logic [3:0]            onda_q, onda_d;
  logic                  batida_pend_q, batida_pend_d;
  logic                  armado_q, armado_d;
  estado_t               estado_q, estado_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  nova_q, fim_q;
  logic                  batida, drena, em_jogo, linha_vazia;

  soma_bcd u_soma (
    .a_i    (pontos_q),
    .soma_o (pontos_mais10)
  );

  // Two-flop synchronizers plus one history register for edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      vivo_s1_q  <= '0;
      vivo_s2_q  <= '0;
      vivo_ant_q <= '0;
      bat_s1_q   <= '0;
      bat_s2_q   <= '0;
      bat_ant_q  <= '0;
    end else if (reiniciarJogo) begin
      vivo_s1_q  <= '0;
      vivo_s2_q  <= '0;
      vivo_ant_q <= '0;
      bat_s1_q   <= '0;
      bat_s2_q   <= '0;
      bat_ant_q  <= '0;
    end else begin
      vivo_s1_q  <= vivo;
      vivo_s2_q  <= vivo_s1_q;
      vivo_ant_q <= vivo_s2_q;
      bat_s1_q   <= n_batidas;
      bat_s2_q   <= bat_s1_q;
      bat_ant_q  <= bat_s2_q;
    end
  end

  // Count enemies that died this cycle and flag a new ship hit.
  always_comb begin
    abatidos = '0;
    for (int unsigned i = 0; i < N_INIMIGOS; i++) begin
      abatidos = abatidos + 8'(vivo_ant_q[i] & ~vivo_s2_q[i]);
    end
    batida      = (bat_s2_q != bat_ant_q) && (bat_s2_q != 2'd0);
    em_jogo     = (estado_q != FIM);
    drena       = em_jogo && !pausa && (pend_q != 3'd0);
    linha_vazia = (vivo_s2_q == '0);
  end

  // Pending kills, score drain and lives bookkeeping.
  always_comb begin
    pend_d        = pend_q;
    pend_soma     = '0;
    pontos_d      = pontos_q;
    vidas_d       = vidas_q;
    batida_pend_d = batida_pend_q;
    if (em_jogo) begin
      pend_soma = 9'(pend_q) + 9'(abatidos) - 9'(drena);
      pend_d    = (pend_soma > 9'd7) ? 3'd7 : pend_soma[2:0];
      if (drena) begin
        pontos_d = pontos_mais10;
      end
      if (!pausa) begin
        if (batida || batida_pend_q) begin
          if (vidas_q != 2'd0) begin
            vidas_d = vidas_q - 2'd1;
          end
          batida_pend_d = 1'b0;
        end
      end else if (batida) begin
        batida_pend_d = 1'b1;
      end
    end
  end

  // Wave sequencing FSM.
  // The "row just emptied" edge lasts one cycle, while the resulting kills are
  // still pending; armado_q remembers it until the drain finishes so LIMPA is
  // entered only once the score is up to date.
  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q;
    onda_d   = onda_q;
    armado_d = linha_vazia && (armado_q || (vivo_ant_q != '0));
    case (estado_q)
      JOGANDO: begin
        if (vidas_q == 2'd0) begin
          estado_d = FIM;
        end else if (armado_q && linha_vazia && (pend_q == 3'd0)) begin
          estado_d = LIMPA;
          armado_d = 1'b0;
          timer_d  = '0;
        end
      end
      LIMPA: begin
        if (vidas_q == 2'd0) begin
          estado_d = FIM;
        end else if (!pausa) begin
          if (timer_q == TW'(ESPERA_ONDA - 1)) begin
            estado_d = NOVA;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      NOVA: begin
        if (onda_q != 4'hF) begin
          onda_d = onda_q + 4'd1;
        end
        timer_d  = '0;
        estado_d = JOGANDO;
      end
      FIM: begin
        estado_d = FIM;
      end
      default: estado_d = JOGANDO;
    endcase
  end

  // Game state registers; restart behaves like reset.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pend_q        <= '0;
      pontos_q      <= '0;
      vidas_q       <= VIDAS_INI;
      onda_q        <= '0;
      batida_pend_q <= 1'b0;
      armado_q      <= 1'b0;
      estado_q      <= JOGANDO;
      timer_q       <= '0;
      nova_q        <= 1'b0;
      fim_q         <= 1'b0;
    end else if (reiniciarJogo) begin
      pend_q        <= '0;
      pontos_q      <= '0;
      vidas_q       <= VIDAS_INI;
      onda_q        <= '0;
      batida_pend_q <= 1'b0;
      armado_q      <= 1'b0;
      estado_q      <= JOGANDO;
      timer_q       <= '0;
      nova_q        <= 1'b0;
      fim_q         <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      pontos_q      <= pontos_d;
      vidas_q       <= vidas_d;
      onda_q        <= onda_d;
      batida_pend_q <= batida_pend_d;
      armado_q      <= armado_d;
      estado_q      <= estado_d;
      timer_q       <= timer_d;
      nova_q        <= (estado_q == NOVA);
      fim_q         <= (estado_q == FIM);
    end
  end

`ifdef PLACAR_RECORDE_EN
  logic [15:0] recorde_q;

  // High score survives restarts; score is frozen while in FIM.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      recorde_q <= '0;
    end else if ((estado_q == FIM) && (pontos_q > recorde_q)) begin
      recorde_q <= pontos_q;
    end
  end

  assign recorde = recorde_q;
`endif

  assign pontos    = pontos_q;
  assign vidas     = vidas_q;
  assign onda      = onda_q;
  assign nova_onda = nova_q;
  assign fim_jogo  = fim_q;

endmodule

// File: tb/tb_placar_fileira.sv
// Self-checking bench for placar_fileira with a cycle-level behavioural model.
module tb_placar_fileira;

  localparam int unsigned N   = 5;
  localparam int unsigned VI  = 3;
  localparam int unsigned ESP = 8;

  localparam int P_JOGO   = 0;
  localparam int P_ESPERA = 1;
  localparam int P_NOVA   = 2;
  localparam int P_FIM    = 3;

  logic         CLOCK_50      = 1'b0;
  logic         reset         = 1'b0;
  logic         reiniciarJogo = 1'b0;
  logic         pausa         = 1'b0;
  logic [N-1:0] vivo          = 5'b11111;
  logic [1:0]   n_batidas     = 2'd0;
  logic [15:0]  pontos;
  logic [1:0]   vidas;
  logic [3:0]   onda;
  logic         nova_onda;
  logic         fim_jogo;
`ifdef PLACAR_RECORDE_EN
  logic [15:0]  recorde;
`endif

  int errors = 0;
  int checks = 0;

  placar_fileira #(
    .N_INIMIGOS     (N),
    .VIDAS_INICIAIS (VI),
    .ESPERA_ONDA    (ESP)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .reiniciarJogo (reiniciarJogo),
    .pausa         (pausa),
    .vivo          (vivo),
    .n_batidas     (n_batidas),
    .pontos        (pontos),
    .vidas         (vidas),
    .onda          (onda),
    .nova_onda     (nova_onda),
`ifdef PLACAR_RECORDE_EN
    .recorde       (recorde),
`endif
    .fim_jogo      (fim_jogo)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nome, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int x);
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // ---------------- behavioural model (decimal score, wait countdown) -----
  logic [N-1:0] m_v1, m_v2, m_v3;
  logic [1:0]   m_b1, m_b2, m_b3;
  int m_pend, m_score, m_lives, m_wave, m_phase, m_wait, m_rec;
  bit m_armed, m_hitp, m_nova, m_fim;

  task automatic zerar(input bit total);
    m_v1 = '0; m_v2 = '0; m_v3 = '0;
    m_b1 = '0; m_b2 = '0; m_b3 = '0;
    m_pend = 0; m_score = 0; m_lives = VI; m_wave = 0;
    m_phase = P_JOGO; m_wait = 0; m_armed = 0; m_hitp = 0;
    m_nova = 0; m_fim = 0;
    if (total) m_rec = 0;
  endtask

  always @(posedge CLOCK_50 or negedge reset) begin : modelo
    int fall, o_phase, o_lives, o_pend, o_score;
    bit hit, empty, drain, o_armed;
    if (!reset) begin
      zerar(1'b1);
    end else if (reiniciarJogo) begin
      zerar(1'b0);
    end else begin
      fall    = $countones(m_v3 & ~m_v2);
      hit     = (m_b2 != m_b3) && (m_b2 != 2'd0);
      empty   = (m_v2 == '0);
      o_phase = m_phase; o_lives = m_lives; o_pend = m_pend;
      o_score = m_score; o_armed = m_armed;
      m_nova  = (o_phase == P_NOVA);
      m_fim   = (o_phase == P_FIM);
      if (o_phase == P_FIM) begin
        if (o_score > m_rec) m_rec = o_score;
      end else begin
        drain = !pausa && (o_pend > 0);
        if (drain) m_score = (o_score + 10 > 9990) ? 9999 : o_score + 10;
        m_pend = o_pend - int'(drain) + fall;
        if (m_pend > 7) m_pend = 7;
        if (!pausa) begin
          if (hit || m_hitp) begin
            if (m_lives > 0) m_lives--;
            m_hitp = 0;
          end
        end else if (hit) begin
          m_hitp = 1;
        end
      end
      m_armed = empty && (o_armed || (m_v3 != '0));
      case (o_phase)
        P_JOGO: begin
          if (o_lives == 0) m_phase = P_FIM;
          else if (o_armed && empty && o_pend == 0) begin
            m_phase = P_ESPERA; m_armed = 0; m_wait = ESP;
          end
        end
        P_ESPERA: begin
          if (o_lives == 0) m_phase = P_FIM;
          else if (!pausa) begin
            m_wait--;
            if (m_wait == 0) m_phase = P_NOVA;
          end
        end
        P_NOVA: begin
          if (m_wave < 15) m_wave++;
          m_phase = P_JOGO;
        end
        default: ;
      endcase
      m_v3 = m_v2; m_v2 = m_v1; m_v1 = vivo;
      m_b3 = m_b2; m_b2 = m_b1; m_b1 = n_batidas;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLOCK_50) begin
    if (reset) begin
      chk("modelo pontos", pontos, bcd(m_score));
      chk("modelo vidas", 16'(vidas), 16'(m_lives));
      chk("modelo onda", 16'(onda), 16'(m_wave));
      chk("modelo nova_onda", 16'(nova_onda), 16'(m_nova));
      chk("modelo fim_jogo", 16'(fim_jogo), 16'(m_fim));
`ifdef PLACAR_RECORDE_EN
      chk("modelo recorde", recorde, bcd(m_rec));
`endif
    end
  end

  // ---------------- directed stimulus with literal expectations -----------
  task automatic ciclos(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic reinicia();
    @(negedge CLOCK_50);
    reiniciarJogo = 1'b1;
    n_batidas     = 2'd0;
    vivo          = 5'b11111;
    pausa         = 1'b0;
    @(negedge CLOCK_50);
    reiniciarJogo = 1'b0;
  endtask

  logic [15:0] t2_pontos [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050};
  logic [N-1:0] t4_vivo  [5] = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};
  logic [15:0] t4_pontos [5] = '{16'h9960, 16'h9970, 16'h9980, 16'h9990, 16'h9999};

  initial begin
    int pulsos;
    ciclos(3);
    reset = 1'b1;
    chk("reset pontos", pontos, 16'h0000);
    chk("reset vidas", 16'(vidas), 16'd3);
    chk("reset onda", 16'(onda), 16'd0);
    chk("reset nova_onda", 16'(nova_onda), 16'd0);
    chk("reset fim_jogo", 16'(fim_jogo), 16'd0);

    // single kill latency
    ciclos(6);
    vivo = 5'b11110;
    ciclos(3);
    chk("kill latencia 3", pontos, 16'h0000);
    ciclos(1);
    chk("kill latencia 4", pontos, 16'h0010);

    // whole row at once, then the wave timer
    reinicia();
    chk("reinicio pontos", pontos, 16'h0000);
    ciclos(5);
    vivo   = 5'b00000;
    pulsos = 0;
    for (int k = 1; k <= 24; k++) begin
      ciclos(1);
      if (k >= 4 && k <= 8) chk("fileira pontos", pontos, t2_pontos[k-4]);
      chk("fileira nova_onda", 16'(nova_onda), (k == 18) ? 16'd1 : 16'd0);
      chk("fileira onda", 16'(onda), (k >= 18) ? 16'd1 : 16'd0);
      if (nova_onda) pulsos++;
    end
    chk("fileira pulsos", 16'(pulsos), 16'd1);

    // pause: kills held then applied, wave delayed by the paused cycles
    reinicia();
    ciclos(5);
    pausa = 1'b1;
    vivo  = 5'b11100;
    ciclos(10);
    chk("pausa pontos retidos", pontos, 16'h0000);
    pausa = 1'b0;
    ciclos(1);
    chk("pausa liberada 1", pontos, 16'h0010);
    ciclos(1);
    chk("pausa liberada 2", pontos, 16'h0020);
    vivo = 5'b00000;
    for (int k = 1; k <= 45; k++) begin
      ciclos(1);
      if (k == 6) chk("pausa pontos fileira", pontos, 16'h0050);
      chk("pausa nova_onda", 16'(nova_onda), (k == 36) ? 16'd1 : 16'd0);
      if (k == 10) pausa = 1'b1;
      if (k == 30) pausa = 1'b0;
    end

    // drive the score up to the ceiling
    reinicia();
    ciclos(5);
    repeat (199) begin
      vivo = 5'b00000;
      ciclos(8);
      vivo = 5'b11111;
      ciclos(8);
    end
    ciclos(10);
    chk("teto 9950", pontos, 16'h9950);
    chk("onda saturada", 16'(onda), 16'hF);
    for (int k = 0; k < 5; k++) begin
      vivo = t4_vivo[k];
      ciclos(6);
      chk("teto passo", pontos, t4_pontos[k]);
    end
    vivo = 5'b11111;
    ciclos(6);
    vivo = 5'b00000;
    ciclos(10);
    chk("teto mantido", pontos, 16'h9999);

    // lives lost to game over at 0120
    reinicia();
    ciclos(5);
    vivo = 5'b00000; ciclos(10);
    vivo = 5'b11111; ciclos(10);
    vivo = 5'b00000; ciclos(10);
    vivo = 5'b11111; ciclos(10);
    vivo = 5'b11100; ciclos(8);
    chk("jogo1 pontos", pontos, 16'h0120);
    n_batidas = 2'd1;
    ciclos(2);
    chk("batida latencia 2", 16'(vidas), 16'd3);
    ciclos(1);
    chk("batida latencia 3", 16'(vidas), 16'd2);
    n_batidas = 2'd2;
    ciclos(3);
    chk("batida 2", 16'(vidas), 16'd1);
    n_batidas = 2'd3;
    ciclos(3);
    chk("batida 3", 16'(vidas), 16'd0);
    ciclos(1);
    chk("fim ainda baixo", 16'(fim_jogo), 16'd0);
    ciclos(1);
    chk("fim alto", 16'(fim_jogo), 16'd1);
`ifdef PLACAR_RECORDE_EN
    chk("recorde jogo1", recorde, 16'h0120);
`endif
    vivo = 5'b11111; ciclos(4);
    vivo = 5'b00000; ciclos(10);
    chk("fim ignora kills", pontos, 16'h0120);
    chk("fim mantido", 16'(fim_jogo), 16'd1);
    reinicia();
    chk("reinicio vidas", 16'(vidas), 16'd3);
    chk("reinicio pontos 2", pontos, 16'h0000);
    chk("reinicio fim", 16'(fim_jogo), 16'd0);

    // second game ends lower; record must hold
    ciclos(5);
    vivo = 5'b00000; ciclos(10);
    chk("jogo2 pontos", pontos, 16'h0050);
    n_batidas = 2'd1; ciclos(5);
    n_batidas = 2'd2; ciclos(5);
    n_batidas = 2'd3; ciclos(6);
    chk("jogo2 fim", 16'(fim_jogo), 16'd1);
`ifdef PLACAR_RECORDE_EN
    chk("recorde mantido", recorde, 16'h0120);
`endif

    // asynchronous reset mid-cycle
    n_batidas = 2'd0;
    #2;
    reset = 1'b0;
    #1;
    chk("reset async pontos", pontos, 16'h0000);
    chk("reset async vidas", 16'(vidas), 16'd3);
    chk("reset async fim", 16'(fim_jogo), 16'd0);
`ifdef PLACAR_RECORDE_EN
    chk("reset async recorde", recorde, 16'h0000);
`endif
    @(negedge CLOCK_50);
    reset = 1'b1;
    ciclos(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
